// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared state type and default sizing for the RO PUF scheduler
package ro_puf_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, COUNT, COMPARE, RESP} sched_state_t;
  localparam int CNT_W_DEF = 16;
  localparam int SETTLE_DEF = 16;
  localparam int WINDOW_DEF = 1024;
endpackage

// File: rtl/ro_pair_sched_if.sv
// ro_pair_sched_if: challenge/response handshake between host logic and the pair scheduler
interface ro_pair_sched_if
  import ro_puf_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int CNT_W = CNT_W_DEF
);
  logic req_valid, req_ready;
  logic [IDX_W-1:0] req_idx_a, req_idx_b;
  logic rsp_valid, rsp_ready, rsp_bit, rsp_tie, rsp_err;
  logic [CNT_W-1:0] rsp_cnt_a, rsp_cnt_b;
  modport master (
    output req_valid, req_idx_a, req_idx_b, rsp_ready,
    input req_ready, rsp_valid, rsp_bit, rsp_tie, rsp_err, rsp_cnt_a, rsp_cnt_b
  );
  modport slave (
    input req_valid, req_idx_a, req_idx_b, rsp_ready,
    output req_ready, rsp_valid, rsp_bit, rsp_tie, rsp_err, rsp_cnt_a, rsp_cnt_b
  );
endinterface

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: synchronizes an async oscillator and counts its rising edges, saturating
module ro_edge_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [2:0] sync_q;
  logic [CNT_W-1:0] cnt_q;
  // two flops resynchronize, the third is the previous sample for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], in_i};
      if (clr_i) cnt_q <= '0;
      else if (en_i && sync_q[1] && !sync_q[2] && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ro_pair_sched.sv
// ro_pair_sched: enables a challenged oscillator pair, counts both over a window, returns the comparison
module ro_pair_sched
  import ro_puf_pkg::*;
#(
  parameter int N_RO = 16,
  parameter int IDX_W = $clog2(N_RO),
  parameter int CNT_W = CNT_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF,
  parameter int WINDOW_CYCLES = WINDOW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  ro_pair_sched_if.slave  bus,
  input  logic [N_RO-1:0] ro_in,
  output logic [N_RO-1:0] ro_en
);
  localparam int TMR_W = $clog2((SETTLE_CYCLES > WINDOW_CYCLES ? SETTLE_CYCLES : WINDOW_CYCLES) + 1);
  localparam logic [2**IDX_W-1:0] IN_RANGE = {(2**IDX_W){1'b1}} >> (2**IDX_W - N_RO);
  sched_state_t state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [IDX_W-1:0] idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [N_RO-1:0] ro_en_q, ro_en_d;
  logic bit_q, bit_d, tie_q, tie_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, cnt_a, cnt_b;
  logic bad;
  assign bad = bus.req_idx_a == bus.req_idx_b || !IN_RANGE[bus.req_idx_a] || !IN_RANGE[bus.req_idx_b];
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst(rst), .in_i(ro_in[idx_a_q]), .clr_i(state_q == SETTLE),
    .en_i(state_q == COUNT), .cnt_o(cnt_a)
  );
  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst(rst), .in_i(ro_in[idx_b_q]), .clr_i(state_q == SETTLE),
    .en_i(state_q == COUNT), .cnt_o(cnt_b)
  );
  // state, timer, latched indices, enables and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmr_q <= '0;
      idx_a_q <= '0;
      idx_b_q <= '0;
      ro_en_q <= '0;
      bit_q <= 1'b0;
      tie_q <= 1'b0;
      err_q <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      ro_en_q <= ro_en_d;
      bit_q <= bit_d;
      tie_q <= tie_d;
      err_q <= err_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end
  // sequencing: accept, settle, count window, compare, hold response until taken
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    idx_a_d = idx_a_q;
    idx_b_d = idx_b_q;
    bit_d = bit_q;
    tie_d = tie_q;
    err_d = err_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        idx_a_d = bus.req_idx_a;
        idx_b_d = bus.req_idx_b;
        if (bad) begin
          state_d = RESP;
          bit_d = 1'b0;
          tie_d = 1'b0;
          err_d = 1'b1;
          cnt_a_d = '0;
          cnt_b_d = '0;
        end else begin
          state_d = SETTLE;
          tmr_d = TMR_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: if (tmr_q == '0) begin
        state_d = COUNT;
        tmr_d = TMR_W'(WINDOW_CYCLES - 1);
      end else tmr_d = tmr_q - 1'b1;
      COUNT: if (tmr_q == '0) state_d = COMPARE;
        else tmr_d = tmr_q - 1'b1;
      COMPARE: begin
        state_d = RESP;
        bit_d = cnt_a > cnt_b;
        tie_d = cnt_a == cnt_b;
        err_d = 1'b0;
        cnt_a_d = cnt_a;
        cnt_b_d = cnt_b;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ro_en_d = (state_d == SETTLE || state_d == COUNT) ?
      (N_RO'(1) << idx_a_d) | (N_RO'(1) << idx_b_d) : '0;
  end
  assign ro_en = ro_en_q;
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_bit = bit_q;
  assign bus.rsp_tie = tie_q;
  assign bus.rsp_err = err_q;
  assign bus.rsp_cnt_a = cnt_a_q;
  assign bus.rsp_cnt_b = cnt_b_q;
endmodule

// File: tb/tb_ro_pair_sched.sv
// tb_ro_pair_sched: scoreboard bench driving toggling oscillator models through the scheduler
module tb_ro_pair_sched;
  localparam int N = 4, S = 4, W = 64;
  typedef struct {
    logic bit_e, tie_e, err_e;
    int alo, ahi, blo, bhi, lat, sat3;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, rsp_ready = 1'b0;
  logic [1:0] idx_a = '0, idx_b = '0;
  logic ro_bit [N] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int half_ns [N] = '{40, 30, 50, 40};
  logic [N-1:0] ro_in, ro_en, ro_en3;
  int n_tests = 0, n_fail = 0;
  exp_t sb[$];
  ro_pair_sched_if #(.IDX_W(2), .CNT_W(8)) ifa ();
  ro_pair_sched_if #(.IDX_W(2), .CNT_W(3)) ifb ();
  assign ifa.req_valid = req_valid;
  assign ifa.req_idx_a = idx_a;
  assign ifa.req_idx_b = idx_b;
  assign ifa.rsp_ready = rsp_ready;
  assign ifb.req_valid = req_valid;
  assign ifb.req_idx_a = idx_a;
  assign ifb.req_idx_b = idx_b;
  assign ifb.rsp_ready = rsp_ready;
  assign ro_in = {ro_bit[3], ro_bit[2], ro_bit[1], ro_bit[0]};
  ro_pair_sched #(.N_RO(N), .CNT_W(8), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(ifa), .ro_in(ro_in), .ro_en(ro_en)
  );
  ro_pair_sched #(.N_RO(N), .CNT_W(3), .SETTLE_CYCLES(S), .WINDOW_CYCLES(W)) dut3 (
    .clk(clk), .rst(rst), .bus(ifb), .ro_in(ro_in), .ro_en(ro_en3)
  );
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_ro
    initial begin
      #(3 * g + 1);
      forever begin
        ro_bit[g] = ~ro_bit[g];
        #(half_ns[g]);
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input int a, input int b, input exp_t e, input int hold);
    logic [N-1:0] mask;
    logic [18:0] snap;
    logic en_ok, busy_ok, stable, rdy_low;
    int k;
    exp_t x;
    mask = e.err_e ? '0 : (4'b1 << a) | (4'b1 << b);
    @(negedge clk);
    req_valid = 1'b1;
    idx_a = 2'(a);
    idx_b = 2'(b);
    sb.push_back(e);
    check("req_ready_idle", ifa.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    en_ok = 1'b1;
    busy_ok = 1'b1;
    k = 1;
    while (!ifa.rsp_valid && k < 300) begin
      if (ro_en !== ((k <= S + W) ? mask : 4'b0)) en_ok = 1'b0;
      if (ifa.req_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    if (ro_en !== 4'b0) en_ok = 1'b0;
    check("ro_en_seq", en_ok, 1);
    check("req_ready_busy", busy_ok, 1);
    check("rsp_latency", k, e.lat);
    x = sb.pop_front();
    check("rsp_bit", ifa.rsp_bit, x.bit_e);
    check("rsp_tie", ifa.rsp_tie, x.tie_e);
    check("rsp_err", ifa.rsp_err, x.err_e);
    check($sformatf("rsp_cnt_a=%0d in %0d..%0d", ifa.rsp_cnt_a, x.alo, x.ahi),
          ifa.rsp_cnt_a >= x.alo && ifa.rsp_cnt_a <= x.ahi, 1);
    check($sformatf("rsp_cnt_b=%0d in %0d..%0d", ifa.rsp_cnt_b, x.blo, x.bhi),
          ifa.rsp_cnt_b >= x.blo && ifa.rsp_cnt_b <= x.bhi, 1);
    if (x.sat3 >= 0) check("cnt_a_saturated", ifb.rsp_cnt_a, x.sat3);
    snap = {ifa.rsp_bit, ifa.rsp_tie, ifa.rsp_err, ifa.rsp_cnt_a, ifa.rsp_cnt_b};
    stable = 1'b1;
    rdy_low = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if ({ifa.rsp_bit, ifa.rsp_tie, ifa.rsp_err, ifa.rsp_cnt_a, ifa.rsp_cnt_b} !== snap || !ifa.rsp_valid)
        stable = 1'b0;
      if (ifa.req_ready !== 1'b0) rdy_low = 1'b0;
    end
    if (hold > 0) begin
      check("hold_stable", stable, 1);
      check("hold_req_ready_low", rdy_low, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", ifa.rsp_valid, 0);
    check("req_ready_back", ifa.req_ready, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", ifa.req_ready, 1);
    check("rst_rsp_valid", ifa.rsp_valid, 0);
    check("rst_ro_en", ro_en, 0);
    check("rst_rsp_fields", {ifa.rsp_bit, ifa.rsp_tie, ifa.rsp_err, ifa.rsp_cnt_a, ifa.rsp_cnt_b}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run(1, 2, '{1'b1, 1'b0, 1'b0, 10, 11, 6, 7, S + W + 2, -1}, 0);
    run(2, 1, '{1'b0, 1'b0, 1'b0, 6, 7, 10, 11, S + W + 2, -1}, 0);
    run(0, 3, '{1'b0, 1'b1, 1'b0, 8, 8, 8, 8, S + W + 2, -1}, 0);
    run(2, 2, '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1, -1}, 0);
    half_ns[0] = 20;
    repeat (10) @(negedge clk);
    run(0, 3, '{1'b1, 1'b0, 1'b0, 16, 16, 8, 8, S + W + 2, 7}, 20);
    @(negedge clk);
    req_valid = 1'b1;
    idx_a = 2'd1;
    idx_b = 2'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (29) @(negedge clk);
    check("ro_en_pre_rst", ro_en, 4'b0110);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ro_en", ro_en, 0);
    check("abort_rsp_valid", ifa.rsp_valid, 0);
    check("abort_req_ready", ifa.req_ready, 1);
    rst = 1'b0;
    run(1, 2, '{1'b1, 1'b0, 1'b0, 10, 11, 6, 7, S + W + 2, -1}, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ro_pair_sched.md
Name: ro_pair_sched

Overview:
- Sequencing controller for the ring-oscillator PUF array.
- Accepts a challenge naming two oscillators, enables only that pair, and lets them settle.
- Counts rising edges of each over a fixed clock window, then compares the counts and returns one response bit plus both raw counts.
- Sits between the challenge/response host logic and the bank of free-running oscillator instances. Those instances have their enables gated by this block.

Parameters:
- N_RO, 16, number of oscillators in the array.
- IDX_W, $clog2(N_RO), width of an oscillator index.
- CNT_W, 16, edge-counter width; counters saturate at 2^CNT_W-1.
- SETTLE_CYCLES, 16, clock cycles between enable and start of counting (≥3; covers synchronizer flush).
- WINDOW_CYCLES, 1024, length of the counting window in clock cycles (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  challenge valid.
- req_ready  out  1  block can accept a challenge.
- req_idx_a  in  IDX_W  first oscillator index.
- req_idx_b  in  IDX_W  second oscillator index.
- ro_in  in  N_RO  raw oscillator outputs, asynchronous to clk.
- ro_en  out  N_RO  per-oscillator enable, registered.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_bit  out  1  1 when cnt_a > cnt_b, else 0.
- rsp_tie  out  1  counts equal.
- rsp_err  out  1  challenge rejected.
- rsp_cnt_a  out  CNT_W  edges counted on oscillator A.
- rsp_cnt_b  out  CNT_W  edges counted on oscillator B.

Behaviour:
- Reset values: state IDLE. req_ready=1 in IDLE. rsp_valid=0, ro_en=0, rsp_bit=0, rsp_tie=0, rsp_err=0, rsp_cnt_a=0, rsp_cnt_b=0.
- Reset in any state aborts the operation: ro_en drops to 0 next cycle and no response is issued.
- States: IDLE, SETTLE, COUNT, COMPARE, RESP.
- req_ready is high only in IDLE. A challenge is accepted on a cycle where req_valid && req_ready; call this cycle T. Indices are latched at T.
- Invalid challenge: idx_a==idx_b, or either index ≥ N_RO.
  - Goes IDLE→RESP directly; rsp_valid is high from T+1.
  - rsp_err=1, rsp_bit=0, rsp_tie=0, counts 0.
  - ro_en is never asserted.
- Valid challenge, IDLE→SETTLE:
  - From T+1, ro_en has exactly bits idx_a and idx_b set; all others are 0.
  - Both edge counters are cleared.
  - SETTLE lasts SETTLE_CYCLES cycles.
- COUNT lasts exactly WINDOW_CYCLES cycles.
  - Each counter increments by 1 per synchronized rising edge detected in a COUNT cycle.
  - Edges in SETTLE, COMPARE or RESP are not counted.
  - Counters saturate; they do not wrap.
- COMPARE, 1 cycle:
  - ro_en returns to 0.
  - Response registers load: rsp_bit=(cnt_a>cnt_b), rsp_tie=(cnt_a==cnt_b), rsp_err=0.
- RESP:
  - rsp_valid first high at cycle T+SETTLE_CYCLES+WINDOW_CYCLES+2.
  - Response outputs hold stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE next cycle, with req_ready=1 and rsp_valid=0.
  - A new challenge cannot be accepted in the same cycle as response consumption.
- Input conditioning: each selected ro_in bit passes through a 2-flop synchronizer, then a rising-edge detector against a third flop.
  - Correct counting requires RO frequency < clk/2. Faster oscillators undercount; this is not flagged.
- Output ordering: rsp_bit is relative to the latched order (A,B). Swapping indices inverts rsp_bit except on a tie.
- rsp_* outputs are undefined except when rsp_valid=1; they are driven stable from registers.

Decomposition:
- Package ro_puf_pkg holds:
  - enum sched_state_t {IDLE, SETTLE, COUNT, COMPARE, RESP};
  - default-width localparams for CNT_W and the window/settle defaults.
- Sub-module ro_edge_counter, instantiated twice (A and B):
  - inputs: clk, rst, async in, clr, en;
  - output: CNT_W saturating count;
  - contains the synchronizer and edge detector.
- The top level muxes ro_in[idx_a] and ro_in[idx_b] into the two counters and holds the FSM and enable generation.

Test Plan:
- Parameters for all scenarios: N_RO=4, SETTLE_CYCLES=4, WINDOW_CYCLES=64, CNT_W=8. Bench models ro_in[i] as toggling with a set period.
- Basic compare: ro_in[1] period 6 clk, ro_in[2] period 10 clk; challenge (1,2) → rsp_bit=1, rsp_cnt_a in 10..11, rsp_cnt_b in 6..7, rsp_valid at T+70, ro_en=4'b0110 during T+1..T+68.
- Order swap: same periods, challenge (2,1) → rsp_bit=0, rsp_tie=0, counts swapped relative to the basic-compare case.
- Tie and error: equal periods 8 on RO0 and RO3 → rsp_tie=1, rsp_bit=0. Challenge (2,2) → rsp_err=1 at T+1, ro_en stays 0.
- Saturation and backpressure: CNT_W=3 with period 4 → rsp_cnt_a=7. Hold rsp_ready=0 for 20 cycles → outputs stable, req_ready=0; then ready → IDLE next cycle.
- Reset mid-COUNT: assert rst at T+30 → next cycle ro_en=0, rsp_valid=0, req_ready=1. A following challenge completes normally with fresh counts.
